// File: rtl/seq_and_or_sched.sv
// seq_and_or_sched
// Shares one and-or evaluation datapath among NREQ requesters. A request is
// arbitrated in IDLE. Its operand bundle is captured into dp_op, and the
// winner gets a one-cycle grant in ISSUE. The block then waits DP_LAT cycles
// for the datapath and returns the sampled dp_n on res with a one-cycle done
// pulse in DONE. Only one operation is in flight at a time.
//
// Configuration macro: SCHED_RR_EN
//   defined   -> round-robin arbitration. The search starts one past the
//                last winner.
//   undefined -> fixed priority. The lowest index wins, and no pointer is kept.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   [NREQ]   level request per requester, held until gnt
//   req_op  in   [7*NREQ] operand bundle per requester {a,b,c,d,e,f,g}
//   gnt     out  [NREQ]   one-hot grant pulse (ISSUE)
//   done    out  [NREQ]   one-hot completion pulse (DONE)
//   res     out  result bit, valid only while done is non-zero
//   dp_op   out  [7]      registered operands to the shared datapath
//   dp_n    in   datapath result
//   busy    out  high whenever the scheduler is not IDLE
module seq_and_or_sched #(
    parameter int NREQ   = 4,
    parameter int DP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [7*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 res,
    output logic [6:0]           dp_op,
    input  logic                 dp_n,
    output logic                 busy
);

    localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state_reg, state_next;
    logic [WW-1:0]   win_reg, win_next;
    logic [6:0]      dp_op_reg;
    logic [1:0]      cnt_reg;
    logic            n_reg;
    logic [6:0]      op_slice [NREQ];

    // Per-requester operand slices and one-hot decode of the held winner.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_slice[gi] = req_op[7*gi +: 7];
            assign gnt[gi]  = (state_reg == ISSUE) && (win_reg == WW'(gi));
            assign done[gi] = (state_reg == DONE)  && (win_reg == WW'(gi));
        end
    endgenerate

`ifdef SCHED_RR_EN
    logic [WW-1:0] ptr_reg;
    int            idx_full;
    logic [WW-1:0] cand;
    logic          found;

    // Walk the requesters starting one past the last winner.
    always_comb begin
        win_next = '0;
        found    = 1'b0;
        idx_full = 0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_full = (int'(ptr_reg) + 1 + k) % NREQ;
            cand     = WW'(idx_full);
            if (!found && req[cand]) begin
                found    = 1'b1;
                win_next = cand;
            end
        end
    end
`else
    // Fixed priority. The scan runs downward, so the lowest index is written last and wins.
    always_comb begin
        win_next = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[WW'(k)]) begin
                win_next = WW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == 2'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            win_reg   <= '0;
            dp_op_reg <= 7'b0;
            cnt_reg   <= 2'd0;
            n_reg     <= 1'b0;
`ifdef SCHED_RR_EN
            ptr_reg   <= WW'(NREQ - 1);
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        win_reg   <= win_next;
                        dp_op_reg <= op_slice[win_next];
                    end
                end
                ISSUE: begin
                    // The counter holds the number of WAIT cycles left after the current one.
                    cnt_reg <= 2'(DP_LAT - 1);
`ifdef SCHED_RR_EN
                    ptr_reg <= win_reg;
`endif
                end
                WAIT: begin
                    if (cnt_reg == 2'd0) begin
                        n_reg <= dp_n;
                    end else begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dp_op = dp_op_reg;
    assign res   = (state_reg == DONE) && n_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_and_or_sched.sv
module tb_seq_and_or_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req1, req3;
    logic [27:0] req_op1, req_op3;
    logic [3:0]  gnt1, done1, gnt3, done3;
    logic        res1, res3, busy1, busy3, dp_n1, dp_n3;
    logic [6:0]  dp_op1, dp_op3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_and_or_sched #(.NREQ(4), .DP_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req1), .req_op(req_op1), .gnt(gnt1),
        .done(done1), .res(res1), .dp_op(dp_op1), .dp_n(dp_n1), .busy(busy1)
    );

    seq_and_or_sched #(.NREQ(4), .DP_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_op(req_op3), .gnt(gnt3),
        .done(done3), .res(res3), .dp_op(dp_op3), .dp_n(dp_n3), .busy(busy3)
    );

    // Datapath stubs: n = (a&b&c&d)|(e&f&g), registered through DP_LAT stages.
    function automatic logic andor(input logic [6:0] o);
        return (o[6] & o[5] & o[4] & o[3]) | (o[2] & o[1] & o[0]);
    endfunction

    logic       n1_q;
    logic [2:0] n3_q;
    always_ff @(posedge clk) begin
        n1_q <= andor(dp_op1);
        n3_q <= {n3_q[1:0], andor(dp_op3)};
    end
    assign dp_n1 = n1_q;
    assign dp_n3 = n3_q[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Place op at slice w and fill the other slices with ~op.
    function automatic logic [27:0] mk(input int w, input logic [6:0] op);
        logic [27:0] v;
        for (int i = 0; i < 4; i++) v[7*i +: 7] = ~op;
        v[7*w +: 7] = op;
        return v;
    endfunction

    // One full operation on the DP_LAT=1 instance. Call it 1 time unit after a rising edge while the instance is idle.
    task automatic txn(input string nm, input logic [3:0] rq, input logic [27:0] ops,
                       input int exp_w, input logic exp_res);
        logic [6:0]  exp_op;
        logic [31:0] oh;
        exp_op  = ops[7*exp_w +: 7];
        oh      = 32'(1) << exp_w;
        req1    = rq;
        req_op1 = ops;
        @(posedge clk); #1;                     // ISSUE
        chk({nm, " gnt"},   32'(gnt1),   oh);
        chk({nm, " dp_op"}, 32'(dp_op1), 32'(exp_op));
        req1[exp_w] = 1'b0;
        req_op1 = ~ops;                         // must not disturb the in-flight operation
        @(posedge clk); #1;                     // WAIT
        chk({nm, " wait gnt/done"}, 32'({gnt1, done1}), 32'(0));
        chk({nm, " wait busy"},     32'(busy1),         32'(1));
        @(posedge clk); #1;                     // DONE
        chk({nm, " done"},  32'(done1),  oh);
        chk({nm, " res"},   32'(res1),   32'(exp_res));
        chk({nm, " held dp_op"}, 32'(dp_op1), 32'(exp_op));
        @(posedge clk); #1;                     // IDLE
        chk({nm, " idle done/res/busy"}, 32'({done1, res1, busy1}), 32'(0));
        $display("txn %s: winner %0d res %0b (want %0d %0b)", nm, exp_w, res1, exp_w, exp_res);
    endtask

    typedef struct {
        logic [3:0] rq;
        logic [6:0] op;
        int         w;
        logic       res;
    } vec_t;

    vec_t vecs [6];
    int   rr_w [5];
    int   g3_w [3];
    logic r3_tab [2];

    initial begin
        int gcyc[$], gwin[$], dcyc[$], dwin[$];
        logic dres[$];

        vecs[0] = '{4'b0100, 7'b1111_011, 2, 1'b1};
        vecs[1] = '{4'b0001, 7'b0000_000, 0, 1'b0};
        vecs[2] = '{4'b0010, 7'b1100_110, 1, 1'b0};
        vecs[3] = '{4'b0010, 7'b0011_111, 1, 1'b1};
        vecs[4] = '{4'b1000, 7'b1111_111, 3, 1'b1};
        vecs[5] = '{4'b1000, 7'b1110_110, 3, 1'b0};
`ifdef SCHED_RR_EN
        rr_w = '{0, 1, 2, 3, 0};
        g3_w = '{0, 1, 0};
`else
        rr_w = '{0, 0, 0, 0, 0};
        g3_w = '{0, 0, 0};
`endif
        r3_tab = '{1'b1, 1'b0};

        rst = 1'b1; req1 = 4'b1111; req3 = 4'b0; req_op1 = '1; req_op3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 32'({gnt1, done1, res1, busy1}), 32'(0));
        chk("reset dp_op",   32'(dp_op1), 32'(0));
        req1 = 4'b0;
        rst  = 1'b0;
        @(posedge clk); #1;
        chk("idle after reset", 32'({gnt1, busy1}), 32'(0));

        for (int i = 0; i < 6; i++)
            txn($sformatf("vec%0d", i), vecs[i].rq, mk(vecs[i].w, vecs[i].op),
                vecs[i].w, vecs[i].res);

        // A request withdrawn before the sampling edge is not granted.
        req1 = 4'b0100; #2; req1 = 4'b0;
        @(posedge clk); #1;
        chk("withdrawn req busy", 32'({gnt1, busy1}), 32'(0));
        @(posedge clk); #1;
        chk("withdrawn req gnt", 32'(gnt1), 32'(0));

        // All four requesters hold their requests. Pointer starts from reset.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 5; i++)
            txn($sformatf("all_req%0d", i), 4'b1111,
                {7'b1111111, 7'b0000111, 7'b1111000, 7'b0000000},
                rr_w[i], (rr_w[i] != 0));

        // Reset while in WAIT aborts the operation. Requests made while rst is high are ignored.
        req1 = 4'b0100; req_op1 = mk(2, 7'b1111111);
        @(posedge clk); #1;                     // ISSUE
        req1 = 4'b0;
        @(posedge clk); #1;                     // WAIT
        chk("pre-abort busy", 32'(busy1), 32'(1));
        rst = 1'b1; req1 = 4'b1111;
        @(posedge clk); #1;
        chk("abort busy/done", 32'({busy1, done1, gnt1}), 32'(0));
        chk("abort dp_op", 32'(dp_op1), 32'(0));
        rst = 1'b0; req1 = 4'b0;
        @(posedge clk); #1;
        chk("post-abort no done", 32'({done1, res1, busy1}), 32'(0));
        txn("after_abort", 4'b1001, {7'b0000000, 7'b0, 7'b0, 7'b0001111}, 0, 1'b1);

        // DP_LAT=3 instance with back-to-back requests from requesters 0 and 1.
        req_op3 = {7'b0, 7'b0, 7'b0000110, 7'b1111000};
        req3    = 4'b0011;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(posedge clk); #1;
            for (int b = 0; b < 4; b++) begin
                if (gnt3[b])  begin gcyc.push_back(cyc); gwin.push_back(b); end
                if (done3[b]) begin dcyc.push_back(cyc); dwin.push_back(b); dres.push_back(res3); end
            end
            if (done3 == 4'b0) chk($sformatf("lat3 res idle c%0d", cyc), 32'(res3), 32'(0));
        end
        req3 = 4'b0;
        chk("lat3 grant count", 32'(gcyc.size()), 32'(3));
        chk("lat3 done count",  32'(dcyc.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < gcyc.size() && i < dcyc.size()) begin
                chk($sformatf("lat3 gnt cycle %0d", i), 32'(gcyc[i]), 32'(i * 6));
                chk($sformatf("lat3 winner %0d", i), 32'(gwin[i]), 32'(g3_w[i]));
                chk($sformatf("lat3 done cycle %0d", i), 32'(dcyc[i]), 32'(i * 6 + 4));
                chk($sformatf("lat3 done id %0d", i), 32'(dwin[i]), 32'(g3_w[i]));
                chk($sformatf("lat3 res %0d", i), 32'(dres[i]), 32'(r3_tab[g3_w[i]]));
                $display("txn lat3_%0d: winner %0d res %0b", i, gwin[i], dres[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
